viterbi_decode_rx: RTL

Parametrised soft-decision Viterbi decoder for rate-1/2 terminated convolutional frames. It is the next-generation decode block in the receive chain. It takes one LLR pair per symbol and runs add-compare-select with modulo-normalised metrics and register-exchange survivors, then packs decoded payload bits into `OUT_W`-bit words. Unlike the current fixed-width top, every width is generic, end-of-frame flush is handled internally, and back-pressure is signalled on `in_rdy`, so no external reset sequencing is needed between frames.

---
 rtl/viterbi_decode_rx.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/viterbi_decode_rx.sv
// viterbi_decode_rx: rate-1/2 soft-decision Viterbi decoder with
// register-exchange survivors, internal end-of-frame flush and word packing.
module viterbi_decode_rx #(
  parameter int LLR_W = 8,
  parameter int K = 7,
  parameter logic [K-1:0] G0 = 7'o171,
  parameter logic [K-1:0] G1 = 7'o133,
  parameter int TB_LEN = 35,
  parameter int METRIC_W = LLR_W + K + 3,
  parameter int OUT_W = 128,
  parameter int LEN_W = $clog2(OUT_W + 1),
  parameter int FRAME_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LLR_W-1:0] LLR0,
  input  logic [LLR_W-1:0] LLR1,
  input  logic             data_in_v,
  input  logic             tail,
  output logic             in_rdy,
  output logic [OUT_W-1:0] decode_out,
  output logic             decode_out_v,
  output logic             tail_v,
  output logic [LEN_W-1:0] tail_length
);

  localparam int SW = K - 1;
  localparam int NS = 1 << SW;
  localparam int CW = $clog2(TB_LEN + 1);
  localparam logic [METRIC_W-1:0] M_LOW =
    {3'b111, {(METRIC_W-3){1'b0}}};

  typedef enum logic {RUN, FLUSH} state_t;

  state_t state_q, state_d;

  logic [METRIC_W-1:0] pm     [NS];
  logic [METRIC_W-1:0] pm_n   [NS];
  logic [TB_LEN-1:0]   surv   [NS];
  logic [TB_LEN-1:0]   surv_n [NS];
  logic [NS-1:0]       sel;

  logic [METRIC_W-1:0] l0, l1;
  logic [FRAME_W-1:0]  n, n_post, n_min;
  logic [CW-1:0]       fcnt, fc0;
  logic                take, dec0, fbit;
  logic                emit_v, emit_bit, fin;
  logic [OUT_W-1:0]    acc, acc_n;
  logic [LEN_W-1:0]    pcnt, pcnt_n;
  logic                flush_w;

  function automatic logic [METRIC_W-1:0] bm(
    input logic [K-1:0]        r,
    input logic [METRIC_W-1:0] a,
    input logic [METRIC_W-1:0] b
  );
    logic [METRIC_W-1:0] x, y;
    x = (^(r & G0)) ? -a : a;
    y = (^(r & G1)) ? -b : b;
    return x + y;
  endfunction

  assign l0 = {{(METRIC_W-LLR_W){LLR0[LLR_W-1]}}, LLR0};
  assign l1 = {{(METRIC_W-LLR_W){LLR1[LLR_W-1]}}, LLR1};

  // State s is reached from {s[SW-2:0],0} and {s[SW-2:0],1} with u = s[SW-1].
  for (genvar s = 0; s < NS; s++) begin : g_acs
    localparam logic [SW-1:0] P0 = SW'((2 * s) % NS);
    localparam logic [SW-1:0] P1 = SW'((2 * s + 1) % NS);
    localparam logic U = 1'((s >> (SW - 1)) & 1);
    logic [METRIC_W-1:0] m0, m1, d;
    assign m0 = pm[P0] + bm({U, P0}, l0, l1);
    assign m1 = pm[P1] + bm({U, P1}, l0, l1);
    assign d = m1 - m0;
    assign sel[s] = ~d[METRIC_W-1] & (|d);
    assign pm_n[s] = sel[s] ? m1 : m0;
    assign surv_n[s] = {sel[s] ? surv[P1][TB_LEN-2:0]
                               : surv[P0][TB_LEN-2:0], U};
  end

  assign dec0 = sel[0] ? surv[1][TB_LEN-1] : surv[0][TB_LEN-1];

  assign in_rdy = (state_q == RUN);
  assign take   = data_in_v & in_rdy;
  assign n_post = n + FRAME_W'(1);
  assign n_min  = (n_post < FRAME_W'(TB_LEN)) ? n_post : FRAME_W'(TB_LEN);
  assign fc0    = (n_min > FRAME_W'(K - 1)) ?
                  CW'(n_min - FRAME_W'(K - 1)) : '0;

  always_comb begin
    fbit = 1'b0;
    for (int i = 0; i < TB_LEN; i++)
      if (CW'(i) == fcnt + CW'(K - 2)) fbit = surv[0][i];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (take && tail) state_d = FLUSH;
      FLUSH:   if (tail_v) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Metrics and survivors return to frame-start values after the tail word.
  always_ff @(posedge clk) begin
    if (rst || (state_q == FLUSH && tail_v)) begin
      for (int s = 0; s < NS; s++) begin
        pm[s]   <= (s == 0) ? '0 : M_LOW;
        surv[s] <= '0;
      end
      n <= '0;
    end else if (take) begin
      pm   <= pm_n;
      surv <= surv_n;
      n    <= n_post;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      emit_v   <= 1'b0;
      emit_bit <= 1'b0;
      fin      <= 1'b0;
      fcnt     <= '0;
    end else begin
      emit_v <= 1'b0;
      fin    <= 1'b0;
      if (take) begin
        emit_v   <= n_post > FRAME_W'(TB_LEN);
        emit_bit <= dec0;
        if (tail) begin
          fcnt <= fc0;
          fin  <= (fc0 == '0);
        end
      end else if (state_q == FLUSH && fcnt != '0) begin
        emit_v   <= 1'b1;
        emit_bit <= fbit;
        fcnt     <= fcnt - CW'(1);
        fin      <= (fcnt == CW'(1));
      end
    end
  end

  always_comb begin
    acc_n = acc;
    for (int i = 0; i < OUT_W; i++)
      if (emit_v && LEN_W'(i) == pcnt) acc_n[i] = emit_bit;
    pcnt_n  = pcnt + LEN_W'(emit_v);
    flush_w = fin | (pcnt_n == LEN_W'(OUT_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      pcnt         <= '0;
      decode_out   <= '0;
      decode_out_v <= 1'b0;
      tail_v       <= 1'b0;
      tail_length  <= '0;
    end else begin
      decode_out_v <= 1'b0;
      tail_v       <= 1'b0;
      if (flush_w) begin
        decode_out   <= acc_n;
        decode_out_v <= 1'b1;
        tail_v       <= fin;
        tail_length  <= pcnt_n;
        acc          <= '0;
        pcnt         <= '0;
      end else begin
        acc  <= acc_n;
        pcnt <= pcnt_n;
      end
    end
  end

endmodule
